// File: rtl/tone_pkg.sv
// Shared types and defaults for the tone sequencer.
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CLK_HZ_DEF = 50_000_000;
    localparam int DEPTH_DEF  = 16;
    localparam int DIV_W_DEF  = 20;
    localparam int DUR_W_DEF  = 24;

    // Half-period divider for a tone frequency, for whoever loads the table.
    function automatic int unsigned hz_to_div(input int unsigned clk_hz,
                                              input int unsigned tone_hz);
        return (tone_hz == 0) ? 0 : clk_hz / (2 * tone_hz);
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: toggles every div cycles, first half low after clear.
module tone_divider #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             wave
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             wave_q, wave_d;

    // Next count/wave: clear wins, div=0 is a rest, wrap at div-1 and toggle.
    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (clear) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (en) begin
            if (div == '0) begin
                cnt_d  = '0;
                wave_d = 1'b0;
            end else if (cnt_q == div - DIV_W'(1)) begin
                cnt_d  = '0;
                wave_d = ~wave_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/tone_player.sv
// Multi-note tone sequencer: plays a writable table of {half-period, duration}
// entries back to back on a start pulse, with optional looping and abort.
module tone_player
    import tone_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DIV_W  = 20,
    parameter int DUR_W  = 24
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iSTART,
    input  logic              iSTOP,
    input  logic              iLOOP,
    input  logic              iWR_EN,
    input  logic [ADDR_W-1:0] iWR_ADDR,
    input  logic [DIV_W-1:0]  iWR_DIV,
    input  logic [DUR_W-1:0]  iWR_DUR,
    output logic              oSOUND,
    output logic              oBUSY,
    output logic              oNOTE_STB,
    output logic [ADDR_W-1:0] oNOTE_IDX,
    output logic              oDONE
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CLK_HZ <= 0) begin : g_bad_param
        $error("tone_player: DEPTH must be a power of two >= 2 and CLK_HZ positive");
    end

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [DUR_W-1:0] dur;
    } note_t;

    note_t             tbl_q [DEPTH];

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              stb_q, stb_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    note_t             cur_q, cur_d;
    logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;

    logic              tone_clr;
    logic              load_note;
    logic [ADDR_W-1:0] load_idx;
    logic [ADDR_W-1:0] nxt_idx;
    logic              dur_last;
    logic              last_entry;
    note_t             first_n, next_n;

    // Note storage: no reset, writes accepted in every state.
    always_ff @(posedge iCLK) begin
        if (iWR_EN) tbl_q[iWR_ADDR] <= '{div: iWR_DIV, dur: iWR_DUR};
    end

    assign nxt_idx    = idx_q + ADDR_W'(1);
    assign first_n    = tbl_q[0];
    assign next_n     = tbl_q[nxt_idx];
    assign last_entry = (idx_q == ADDR_W'(DEPTH - 1));
    assign dur_last   = (dur_cnt_q == cur_q.dur - DUR_W'(1));

    // Sequencer next state: continue note, advance, loop, finish or abort.
    always_comb begin
        state_d   = state_q;
        busy_d    = 1'b0;
        stb_d     = 1'b0;
        done_d    = 1'b0;
        idx_d     = idx_q;
        cur_d     = cur_q;
        dur_cnt_d = dur_cnt_q;
        tone_clr  = 1'b1;
        load_note = 1'b0;
        load_idx  = '0;
        unique case (state_q)
            IDLE: begin
                if (iSTART && !iSTOP) begin
                    if (first_n.dur == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        load_note = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (iSTOP) begin
                    state_d = IDLE;
                end else if (!dur_last) begin
                    busy_d    = 1'b1;
                    dur_cnt_d = dur_cnt_q + DUR_W'(1);
                    tone_clr  = 1'b0;
                end else if (!last_entry && next_n.dur != '0) begin
                    load_note = 1'b1;
                    load_idx  = nxt_idx;
                end else if (iLOOP && first_n.dur != '0) begin
                    // Loop restart; an entry 0 emptied mid-play ends the run instead.
                    load_note = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Snapshot the entry so later writes cannot disturb the playing note.
        if (load_note) begin
            state_d   = PLAY;
            busy_d    = 1'b1;
            stb_d     = 1'b1;
            idx_d     = load_idx;
            cur_d     = tbl_q[load_idx];
            dur_cnt_d = '0;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            stb_q     <= 1'b0;
            done_q    <= 1'b0;
            idx_q     <= '0;
            cur_q     <= '0;
            dur_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            stb_q     <= stb_d;
            done_q    <= done_d;
            idx_q     <= idx_d;
            cur_q     <= cur_d;
            dur_cnt_q <= dur_cnt_d;
        end
    end

    tone_divider #(.DIV_W(DIV_W)) u_div (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .clear (tone_clr),
        .en    (state_q == PLAY),
        .div   (cur_q.div),
        .wave  (oSOUND)
    );

    assign oBUSY     = busy_q;
    assign oNOTE_STB = stb_q;
    assign oNOTE_IDX = idx_q;
    assign oDONE     = done_q;

endmodule

// File: tb/tb_tone_player.sv
// Randomized bench for tone_player against a note-level playback model.
module tb_tone_player;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DIV_W  = 8;
    localparam int DUR_W  = 8;

    logic              iCLK = 1'b0;
    logic              iRST_N;
    logic              iSTART, iSTOP, iLOOP, iWR_EN;
    logic [ADDR_W-1:0] iWR_ADDR;
    logic [DIV_W-1:0]  iWR_DIV;
    logic [DUR_W-1:0]  iWR_DUR;
    logic              oSOUND, oBUSY, oNOTE_STB, oDONE;
    logic [ADDR_W-1:0] oNOTE_IDX;

    int n_chk  = 0;
    int n_fail = 0;
    int m_div [DEPTH];
    int m_dur [DEPTH];

    tone_player #(
        .CLK_HZ (50_000_000),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DIV_W  (DIV_W),
        .DUR_W  (DUR_W)
    ) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iSTART    (iSTART),
        .iSTOP     (iSTOP),
        .iLOOP     (iLOOP),
        .iWR_EN    (iWR_EN),
        .iWR_ADDR  (iWR_ADDR),
        .iWR_DIV   (iWR_DIV),
        .iWR_DUR   (iWR_DUR),
        .oSOUND    (oSOUND),
        .oBUSY     (oBUSY),
        .oNOTE_STB (oNOTE_STB),
        .oNOTE_IDX (oNOTE_IDX),
        .oDONE     (oDONE)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_busy"}, oBUSY, 0);
        check({tag, "_sound"}, oSOUND, 0);
        check({tag, "_stb"}, oNOTE_STB, 0);
        check({tag, "_done"}, oDONE, 0);
    endtask

    // Table write; model copy updated once the write edge has passed.
    task automatic wr(input int a, input int d, input int u);
        iWR_EN   = 1'b1;
        iWR_ADDR = ADDR_W'(a);
        iWR_DIV  = DIV_W'(d);
        iWR_DUR  = DUR_W'(u);
        @(negedge iCLK);
        iWR_EN = 1'b0;
        m_div[a] = d;
        m_dur[a] = u;
    endtask

    // Start playback and compare every cycle against the note list.
    // stop_at/wr_at are 1-based cycle numbers after start; 0 disables.
    task automatic play(input bit loop, input int stop_at, input int wr_at,
                        input int wa, input int wd, input int wu);
        int  cyc, i, c, dv, du;
        bit  fin, wpend;
        iLOOP  = loop;
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        if (m_dur[0] == 0) begin
            check("empty_done", oDONE, 1);
            check("empty_stb", oNOTE_STB, 0);
            check("empty_busy", oBUSY, 0);
            @(negedge iCLK);
            chk_idle("empty_after");
            iLOOP = 1'b0;
            return;
        end
        cyc = 1; i = 0; c = 0; fin = 0; wpend = 0;
        dv = m_div[0]; du = m_dur[0];
        while (!fin) begin
            if (wpend) begin
                m_div[wa] = wd; m_dur[wa] = wu;
                iWR_EN = 1'b0; wpend = 0;
            end
            check("busy", oBUSY, 1);
            check("stb", oNOTE_STB, (c == 0));
            check("idx", oNOTE_IDX, i);
            check("sound", oSOUND, (dv == 0) ? 0 : ((c / dv) % 2));
            check("done", oDONE, 0);
            if (cyc == stop_at) begin
                iSTOP = 1'b1;
                @(negedge iCLK);
                iSTOP = 1'b0;
                chk_idle("stop");
                @(negedge iCLK);
                chk_idle("stop_hold");
                iLOOP = 1'b0;
                return;
            end
            if (cyc == wr_at) begin
                iWR_EN   = 1'b1;
                iWR_ADDR = ADDR_W'(wa);
                iWR_DIV  = DIV_W'(wd);
                iWR_DUR  = DUR_W'(wu);
                wpend    = 1;
            end
            c++;
            if (c == du) begin
                if (i == DEPTH - 1 || m_dur[i + 1] == 0) begin
                    if (loop && m_dur[0] != 0) i = 0;
                    else fin = 1;
                end else begin
                    i++;
                end
                c = 0; dv = m_div[i]; du = m_dur[i];
            end
            @(negedge iCLK);
            cyc++;
            if (cyc > 3000) begin
                check("play_timeout", cyc, 0);
                iLOOP = 1'b0; iWR_EN = 1'b0;
                return;
            end
        end
        if (wpend) begin
            m_div[wa] = wd; m_dur[wa] = wu;
            iWR_EN = 1'b0;
        end
        check("end_done", oDONE, 1);
        check("end_busy", oBUSY, 0);
        check("end_sound", oSOUND, 0);
        check("end_stb", oNOTE_STB, 0);
        @(negedge iCLK);
        chk_idle("end_after");
        iLOOP = 1'b0;
    endtask

    initial begin
        int e, lp;
        iRST_N = 1'b0; iSTART = 0; iSTOP = 0; iLOOP = 0; iWR_EN = 0;
        iWR_ADDR = '0; iWR_DIV = '0; iWR_DUR = '0;
        repeat (2) @(negedge iCLK);
        chk_idle("reset");
        check("reset_idx", oNOTE_IDX, 0);
        iRST_N = 1'b1;
        @(negedge iCLK);
        for (int a = 0; a < DEPTH; a++) wr(a, 0, 0);

        // single note
        wr(0, 2, 8); wr(1, 0, 0);
        play(0, 0, 0, 0, 0, 0);

        // three notes including a rest
        wr(0, 3, 6); wr(1, 0, 4); wr(2, 1, 4); wr(3, 0, 0);
        play(0, 0, 0, 0, 0, 0);

        // loop, rewrite the playing entry mid-note, then abort
        play(1, 40, 3, 0, 2, 6);

        // full table, no end marker
        for (int a = 0; a < DEPTH; a++) wr(a, $urandom_range(0, 3), 2);
        play(0, 0, 0, 0, 0, 0);

        // empty sequence
        wr(0, 1, 0);
        play(0, 0, 0, 0, 0, 0);

        // start and stop together stays idle
        wr(0, 2, 5); wr(1, 0, 0);
        iSTART = 1'b1; iSTOP = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0; iSTOP = 1'b0;
        chk_idle("start_stop");
        @(negedge iCLK);
        chk_idle("start_stop_hold");

        // asynchronous reset in the middle of a note
        wr(0, 1, 20);
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        @(negedge iCLK);
        check("pre_rst_sound", oSOUND, 1);
        check("pre_rst_busy", oBUSY, 1);
        #2 iRST_N = 1'b0;
        #1;
        chk_idle("async_rst");
        check("async_rst_idx", oNOTE_IDX, 0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);
        chk_idle("post_rst");

        // randomized tables
        for (int it = 0; it < 12; it++) begin
            e  = $urandom_range(1, DEPTH);
            lp = $urandom_range(0, 1);
            for (int a = 0; a < DEPTH; a++)
                wr(a, $urandom_range(0, 4), (a < e) ? $urandom_range(1, 5) : 0);
            play(lp[0], lp ? $urandom_range(3, 80) : 0, 0, 0, 0, 0);
            repeat ($urandom_range(0, 3)) @(negedge iCLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_player.md
# tone_player

Parametrised multi-note tone sequencer driving a piezo/speaker square-wave output. It is the successor of the fixed single-tone sound generator. Holds a writable table of up to DEPTH notes (half-period divider plus duration each) and plays them in order on a start pulse, with optional looping, stop and per-note strobes. Sits between the board clock and the speaker pin; a controller or UI block loads the table and starts playback.

## Interface
- CLK_HZ, 50_000_000: board clock frequency (documentation/derived constants only)
- DEPTH, 16: number of note entries (power of two, ≥2)
- ADDR_W, $clog2(DEPTH): entry index width
- DIV_W, 20: half-period divider width (clock cycles)
- DUR_W, 24: note duration width (clock cycles)

Ports:
- iCLK  in  1  system clock, all logic on rising edge
- iRST_N  in  1  asynchronous, active-low reset
- iSTART  in  1  start playback from entry 0 (sampled in IDLE only)
- iSTOP  in  1  abort playback (priority over iSTART)
- iLOOP  in  1  when 1 at sequence end, restart at entry 0 instead of finishing
- iWR_EN  in  1  write note entry
- iWR_ADDR  in  ADDR_W  entry index to write
- iWR_DIV  in  DIV_W  half-period in clocks; 0 = rest (silence)
- iWR_DUR  in  DUR_W  note length in clocks; 0 = end-of-sequence marker
- oSOUND  out  1  square-wave output
- oBUSY  out  1  high while playing
- oNOTE_STB  out  1  one-cycle pulse at first cycle of each note
- oNOTE_IDX  out  ADDR_W  index of current note
- oDONE  out  1  one-cycle pulse on normal sequence completion

## Operation
- States: IDLE, PLAY, DONE.
- IDLE: oSOUND=0, oBUSY=0. iSTART=1 (and iSTOP=0) → latch entry 0; if its DUR=0 → DONE, else PLAY at idx 0.
- PLAY: entry {DIV,DUR} latched at note start; later table writes to that entry do not affect the current note. Tone counter reset to 0 and oSOUND=0 at note start; counter increments each cycle; at count=DIV-1 toggle oSOUND and clear counter. DIV=0 → oSOUND held 0. DIV=1 → toggle every cycle.
- Duration counter counts DUR cycles; on the last cycle evaluate next: next idx = idx+1; if idx=DEPTH-1 or entry[idx+1].DUR=0 → sequence end; else latch next entry, oNOTE_STB next cycle.
- Sequence end: iLOOP=1 → restart at entry 0 (pulse oNOTE_STB, no oDONE); iLOOP=0 → DONE.
- DONE: single cycle, oDONE=1, oBUSY=0, oSOUND=0; then IDLE.
- iSTOP=1 in any state → IDLE next cycle, oSOUND=0, no oDONE.
- Writes accepted in every state; table contents not cleared by reset (no reset on storage array).
- iSTART in PLAY/DONE ignored.

## Timing
- Reset values: oSOUND=0, oBUSY=0, oNOTE_STB=0, oNOTE_IDX=0, oDONE=0, state IDLE.
- Start latency: iSTART sampled at edge N → oBUSY=1, oNOTE_STB=1, oNOTE_IDX=0 during cycle N+1.
- Each note occupies exactly DUR cycles of oBUSY; consecutive notes back-to-back, no gap cycles.
- Square period = 2·DIV cycles, first half low.
- Write at edge N visible to any note latched at edge N+1 or later.
- Reset mid-note: all outputs return to reset values immediately (asynchronous).

## Structure
- Package tone_pkg: state enum (IDLE/PLAY/DONE), packed note_t {div, dur} struct parameterised via package localparams or typedef in module.
- One sub-module: tone_divider (DIV_W counter + toggle, inputs clear/en/div, output wave).
- Storage: DEPTH×(DIV_W+DUR_W) register array, combinational read.

## Test plan
- Reset: assert iRST_N=0 mid-note → all outputs 0 in same cycle; after release, IDLE.
- Single note: entry0 {DIV=2,DUR=8}, entry1 DUR=0, pulse iSTART → oSOUND 0,0,1,1,0,0,1,1; oBUSY 8 cycles; oDONE pulse on 9th cycle.
- Three notes incl. rest: {3,6},{0,4},{1,4}, entry3 DUR=0 → oNOTE_STB at cycles 1,7,11; silence during idx1; toggle every cycle on idx2; oDONE at cycle 15.
- Loop: same table, iLOOP=1 → oNOTE_IDX returns to 0 after idx2, no oDONE; iSTOP → IDLE next cycle, oSOUND=0, no oDONE.
- Full table: all DEPTH entries DUR=2 → plays DEPTH notes, ends after idx DEPTH-1 without reading past end.
- Edge cases: entry0 DUR=0 + iSTART → oDONE on next cycle, no oNOTE_STB; iSTART+iSTOP same cycle → stays IDLE; write to current entry mid-note → current note unchanged, new value used on next loop.
